// File: rtl/uart_rx_flex.sv
// uart_rx_flex: oversampling UART receiver with majority-voted sampling,
// configurable data/parity/stop bits and a valid/ready word handoff.
module uart_rx_flex #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_raw,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_ML  = TW'(M - 1);
    localparam logic [TW-1:0] T_M   = TW'(M);
    localparam logic [TW-1:0] T_MP  = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d, dout_q, dout_d;
    logic                   fe_q, fe_d, pe_q, pe_d;
    logic                   valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic                   rx_s, maj, at_mid, at_end, done;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign at_mid = sample_tick && tick_q == T_MP;
    assign at_end = sample_tick && tick_q == T_END;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = 1'b0;
        done    = 1'b0;
        if (sample_tick) begin
            tick_d = (tick_q == T_END) ? '0 : tick_q + TW'(1);
            if (tick_q == T_ML) smp_d[0] = rx_s;
            if (tick_q == T_M)  smp_d[1] = rx_s;
        end
        case (state_q)
            IDLE: if (sample_tick && !rx_s) begin
                tick_d  = '0;
                fe_d    = 1'b0;
                pe_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (at_mid && maj) state_d = IDLE;
                else if (at_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else bit_d = bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (at_mid) pe_d = ^shift_q ^ maj ^ (PARITY_MODE == 2);
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_mid) begin
                    fe_d = fe_q | !maj;
                    // finishing mid-bit leaves half a bit to catch an early start edge
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = maj ? IDLE : WAIT_IDLE;
                    end
                end else if (at_end) bit_d = bit_q + BW'(1);
            end
            WAIT_IDLE: if (sample_tick && rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done && (!valid_q || data_ready)) begin
            dout_d  = shift_q;
            ferr_d  = fe_q | !maj;
            perr_d  = pe_q;
            valid_d = 1'b1;
        end else begin
            ovr_d = done;
            if (valid_q && data_ready) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '1;
            tick_q  <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_raw};
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign framing_err = ferr_q;
    assign parity_err  = perr_q;
    assign overrun_err = ovr_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_flex.sv
// tb_uart_rx_flex: four receiver variants (8N1, 8E1, 8O1, 8N2) driven by directed
// frames; a scoreboard queue per variant is checked on every accepted word.
module tb_uart_rx_flex;
    logic       clk = 0, rst_n = 0, tick = 1, ready = 1;
    logic [3:0] rx = '1;
    logic [7:0] dout [4];
    logic [3:0] valid, ferr, perr, ovr, busy;
    int         checks = 0, errors = 0;
    int         acc [4] = '{default: 0};
    int         ovc [4] = '{default: 0};
    logic [9:0] q [4][$];
    int         a, o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_rx_flex #(
            .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(g == 3 ? 0 : g),
            .STOP_BITS(g == 3 ? 2 : 1), .SYNC_STAGES(2)
        ) u (
            .clk(clk), .rst_n(rst_n), .rx_raw(rx[g]), .sample_tick(tick),
            .data_out(dout[g]), .data_valid(valid[g]), .data_ready(ready),
            .framing_err(ferr[g]), .parity_err(perr[g]), .overrun_err(ovr[g]),
            .busy(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int idx, input logic b);
        rx[idx] = b;
        idle(16);
    endtask

    // par < 0 means no parity bit; s2v is the value of the second stop bit
    task automatic send_frame(input int idx, input logic [7:0] d, input int par,
                              input int nstop, input logic s2v);
        send_bit(idx, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(idx, d[i]);
        if (par >= 0) send_bit(idx, par[0]);
        send_bit(idx, 1'b1);
        if (nstop == 2) send_bit(idx, s2v);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    if (ovr[i] === 1'b1) ovc[i]++;
                    if (valid[i] === 1'b1 && ready) begin
                        acc[i]++;
                        chk($sformatf("sb_present%0d", i), 16'(q[i].size() != 0), 16'd1);
                        if (q[i].size() != 0)
                            chk($sformatf("sb_frame%0d", i), 16'({perr[i], ferr[i], dout[i]}),
                                16'(q[i].pop_front()));
                    end
                end
            end
        join_none

        idle(3);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_ovr", 16'(ovr), 16'h0);
        chk("rst_dout0", 16'(dout[0]), 16'h0);
        rst_n = 1;
        idle(5);

        a = acc[0];
        q[0].push_back({2'b00, 8'hA5});
        send_frame(0, 8'hA5, -1, 1, 1'b1);
        idle(16);
        chk("a5_once", 16'(acc[0] - a), 16'd1);
        chk("a5_valid_clr", 16'(valid[0]), 16'd0);

        q[1].push_back({2'b10, 8'h03});
        send_frame(1, 8'h03, 1, 1, 1'b1);
        idle(16);
        q[1].push_back({2'b00, 8'h03});
        send_frame(1, 8'h03, 0, 1, 1'b1);
        idle(16);
        q[2].push_back({2'b00, 8'h03});
        send_frame(2, 8'h03, 1, 1, 1'b1);
        idle(16);
        q[2].push_back({2'b10, 8'h03});
        send_frame(2, 8'h03, 0, 1, 1'b1);
        idle(16);

        a = acc[0];
        rx[0] = 0;
        idle(4);
        rx[0] = 1;
        idle(30);
        chk("glitch_busy", 16'(busy[0]), 16'd0);
        chk("glitch_nodata", 16'(acc[0] - a), 16'd0);
        q[0].push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, -1, 1, 1'b1);
        idle(16);
        chk("5a_once", 16'(acc[0] - a), 16'd1);

        a = acc[3];
        q[3].push_back({2'b01, 8'h3C});
        send_frame(3, 8'h3C, -1, 2, 1'b0);
        idle(48);
        chk("brk_busy", 16'(busy[3]), 16'd1);
        chk("brk_one_frame", 16'(acc[3] - a), 16'd1);
        rx[3] = 1;
        idle(32);
        chk("brk_idle", 16'(busy[3]), 16'd0);
        q[3].push_back({2'b00, 8'h11});
        send_frame(3, 8'h11, -1, 2, 1'b1);
        idle(16);
        chk("11_rcvd", 16'(acc[3] - a), 16'd2);

        ready = 0;
        a = acc[0];
        o = ovc[0];
        q[0].push_back({2'b00, 8'h01});
        send_frame(0, 8'h01, -1, 1, 1'b1);
        idle(16);
        send_frame(0, 8'h02, -1, 1, 1'b1);
        idle(16);
        chk("ovr_pulse", 16'(ovc[0] - o), 16'd1);
        chk("ovr_keep", 16'(dout[0]), 16'h01);
        chk("ovr_valid", 16'(valid[0]), 16'd1);
        chk("ovr_noacc", 16'(acc[0] - a), 16'd0);
        ready = 1;
        idle(3);
        chk("ovr_acc", 16'(acc[0] - a), 16'd1);
        chk("ovr_valid_clr", 16'(valid[0]), 16'd0);

        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 8'h7E >> i);
        rx[0] = 1;
        idle(8);
        chk("mid_busy", 16'(busy[0]), 16'd1);
        rst_n = 0;
        idle(1);
        chk("mrst_dout", 16'(dout[0]), 16'h0);
        chk("mrst_flags", 16'({valid[0], ferr[0], perr[0], ovr[0]}), 16'h0);
        chk("mrst_busy", 16'(busy[0]), 16'd0);
        rst_n = 1;
        idle(32);
        q[0].push_back({2'b00, 8'h7E});
        send_frame(0, 8'h7E, -1, 1, 1'b1);
        idle(20);

        for (int i = 0; i < 4; i++) chk($sformatf("sb_empty%0d", i), 16'(q[i].size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_flex.md
Name: uart_rx_flex

Overview:
- Parametrised UART receive core; successor to the fixed 8N1 bit detector.
- Synchronises the raw RX line, oversamples on a shared baud-tick enable, and validates the start bit with a 3-sample majority vote.
- Supports configurable data bits, parity and stop bits, and hands each received word to the host over a valid/ready interface with per-frame error flags.
- Sits between the pad synchroniser domain and the RX FIFO/host register block.

Parameters:
- OVERSAMPLE, 16: sample ticks per bit; even, minimum 8.
- DATA_BITS, 8: data bits per frame; range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: synchroniser flops on rx_raw; minimum 2.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset
- rx_raw  in  1  asynchronous serial input; idle level is high
- sample_tick  in  1  one-cycle strobe at OVERSAMPLE x baud rate; all timing advances only on this strobe
- data_out  out  DATA_BITS  received word, LSB received first
- data_valid  out  1  data_out and its error flags are valid
- data_ready  in  1  host accepts the word when data_valid && data_ready
- framing_err  out  1  stop bit(s) sampled low; qualified by data_valid
- parity_err  out  1  parity mismatch; qualified by data_valid; always 0 when PARITY_MODE = 0
- overrun_err  out  1  one-cycle pulse when a completed frame is dropped
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n is synchronous and active-low; clock is clk):
  - Synchroniser flops reset to 1.
  - State returns to IDLE.
  - data_out = 0; data_valid, framing_err, parity_err, overrun_err and busy all = 0.
  - All counters = 0.
  - Reset mid-frame abandons the frame with no output.
- Counters:
  - Tick counter width is $clog2(OVERSAMPLE). It increments on sample_tick and wraps OVERSAMPLE-1 -> 0.
  - Bit counter width is $clog2(DATA_BITS+1).
- Mid-point sampling: M = OVERSAMPLE/2. A bit value is the majority of the synced line at tick counts M-1, M and M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - On a sample_tick with the synced line = 0, clear the tick counter and go to START.
- START:
  - At tick M+1, evaluate the majority.
  - If the majority is 1 (glitch), go to IDLE; nothing is output.
  - Otherwise, at tick OVERSAMPLE-1, go to DATA with the bit counter = 0.
- DATA:
  - Shift the majority value in at tick M+1, LSB first.
  - At tick OVERSAMPLE-1, increment the bit counter.
  - After DATA_BITS bits, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - Sample at M+1.
  - Even mode: XOR of the data bits and the parity bit must be 0. Odd mode: it must be 1.
  - Go to STOP at tick OVERSAMPLE-1.
- STOP:
  - Sample each stop bit at M+1; any stop sample = 0 sets the frame's framing error.
  - Frame completes at the M+1 tick of the last stop bit (no wait for end of bit). This allows resync to a start edge arriving up to half a bit early.
  - On completion, go to IDLE if the last stop sample = 1. Otherwise (break/low line) go to WAIT_IDLE.
- WAIT_IDLE: go to IDLE on the first sample_tick where the synced line = 1. No start detection while in this state.
- Completion and output handshake:
  - If data_valid = 0, or data_valid && data_ready in the same cycle: on the next clock load data_out, framing_err and parity_err, and set data_valid = 1.
  - Otherwise: drop the new frame, keep the old word and flags, and pulse overrun_err for one cycle.
  - data_valid holds until accepted. On acceptance with no new completion, data_valid clears on the next clock.
  - Accept and completion in the same cycle must not lose either word.
  - Latency: data_valid rises 1 clk after the completing sample_tick cycle.
- Frames with framing or parity errors are still delivered.
- sample_tick low for any number of cycles freezes all state.

Test Plan:
- OVERSAMPLE=16, 8N1, tick every cycle, send 0xA5 (line 0, then 1,0,1,0,0,1,0,1, then 1), data_ready=1 -> data_valid pulses once, data_out=0xA5, framing_err=0, parity_err=0.
- Even parity, send 0x03 with parity bit 1 -> parity_err=1 and data_out=0x03. Repeat with parity bit 0 -> parity_err=0. Odd mode with parity bit 1 -> parity_err=0.
- Low glitch of 4 ticks on an idle line -> no data_valid, busy returns to 0, next clean frame 0x5A received correctly.
- STOP_BITS=2, second stop bit held low, then line low for 3 bit times -> framing_err=1 with data; no spurious frame during the low period; next frame 0x11 received after the line returns high.
- data_ready=0, two frames 0x01 then 0x02 -> data_out stays 0x01, overrun_err pulses once; raising data_ready -> 0x01 accepted, data_valid drops.
- Assert rst_n=0 mid-DATA (bit 4) -> all outputs 0 the next clock, busy=0; frame 0x7E after release received intact.
